// File: rtl/serial_rr_scheduler.sv
// Purpose: round-robin shares one LSB-first serializer among NUM_REQ word requesters, tagging bits with source id.
// Latency: word accepted on edge T drives bit 0 in cycle T+1, last bit in cycle T+DATA_WIDTH; back-to-back words have no bubble.
// Backpressure: stall freezes shifting and arbitration; req_ready is offered only in IDLE or on the last bit cycle.
module serial_rr_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          stall,
    output logic                          dout,
    output logic                          dout_valid,
    output logic                          dout_last,
    output logic [ID_W-1:0]               dout_id
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shifter;
    logic [CNT_W-1:0]      r_cnt;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_id;

    logic                  w_found;
    logic [ID_W-1:0]       w_grant;
    logic                  w_at_last;
    logic                  w_lo;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_word;
    logic [ID_W-1:0]       w_ptr_next;

    // Pick the first valid requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_grant = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_at_last  = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
    assign w_lo       = !reset && !stall && ((r_state == ST_IDLE) || w_at_last);
    assign w_accept   = w_lo && w_found;
    assign w_word     = req_data[w_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_next = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + ID_W'(1);

    // One-hot ready toward the winner only while a load slot is open.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign dout       = r_shifter[0];
    assign dout_valid = (r_state == ST_SHIFT) && !stall;
    assign dout_last  = w_at_last;
    assign dout_id    = r_id;

    // Load on accept, otherwise shift one bit per unstalled cycle and drop to IDLE after the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shifter <= '0;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_id      <= '0;
        end else if (!stall) begin
            if (w_accept) begin
                r_state   <= ST_SHIFT;
                r_shifter <= w_word;
                r_cnt     <= '0;
                r_id      <= w_grant;
                r_ptr     <= w_ptr_next;
            end else if (r_state == ST_SHIFT) begin
                r_shifter <= {1'b0, r_shifter[DATA_WIDTH-1:1]};
                if (r_cnt == LAST_CNT) begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_rr_scheduler.sv
// Purpose: directed self-checking bench for serial_rr_scheduler with DATA_WIDTH=16, NUM_REQ=4.
// Latency: inputs change just after the falling edge; outputs are checked 1 ns later, away from the rising edge.
// Backpressure: stall and reset are driven per scenario; all loops run fixed cycle counts.
module tb_serial_rr_scheduler;

    localparam int DW = 16;
    localparam int NR = 4;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             stall;
    logic             dout;
    logic             dout_valid;
    logic             dout_last;
    logic [1:0]       dout_id;

    int n_cmp;
    int n_fail;

    logic [DW-1:0] words [NR];

    serial_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .stall      (stall),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .dout_id    (dout_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_words();
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = words[i];
        end
    endtask

    // Advance to the next falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc();
        reset     = 1'b1;
        req_valid = '0;
        stall     = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = 4'b1111;
        cyc();
        cyc();
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        n_cmp++;
        if ({dout, dout_valid, dout_last} !== 3'b000) begin
            n_fail++; $display("FAIL reset_outs got dout/valid/last=%b want=000", {dout, dout_valid, dout_last});
        end
        n_cmp++;
        if (dout_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d want=0", dout_id); end
        req_valid = '0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        logic [DW-1:0] w;
        logic [DW-1:0] exp_bits;
        w        = 16'hA5C3;
        exp_bits = 16'b1010_0101_1100_0011;
        words[2] = w;
        load_words();
        do_reset();
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b want=0100", req_ready); end
        cyc();
        req_valid = '0;
        for (int k = 0; k < DW; k++) begin
            #1;
            n_cmp++;
            if ({dout_valid, dout, dout_last, dout_id} !== {1'b1, exp_bits[k], (k == DW - 1), 2'd2}) begin
                n_fail++;
                $display("FAIL single_bit%0d got valid/dout/last/id=%b/%b/%b/%0d want 1/%b/%b/2",
                         k, dout_valid, dout, dout_last, dout_id, exp_bits[k], (k == DW - 1));
            end
            n_cmp++;
            if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_bit%0d got=%b want=0000", k, req_ready); end
            cyc();
        end
        #1;
        n_cmp++;
        if ({dout_valid, dout, dout_last} !== 3'b000) begin
            n_fail++; $display("FAIL single_idle got valid/dout/last=%b want=000", {dout_valid, dout, dout_last});
        end
    endtask

    task automatic test_round_robin();
        int          run;
        logic [1:0]  id_exp;
        logic [NR-1:0] rdy_exp;
        words[0] = 16'h0F01;
        words[1] = 16'hF0F3;
        words[2] = 16'h3C5A;
        words[3] = 16'hC3A7;
        load_words();
        do_reset();
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_ready got=%b want=0001", req_ready); end
        for (int w = 0; w < 5; w++) begin
            id_exp  = 2'(w % NR);
            rdy_exp = 4'b0001 << ((w + 1) % NR);
            run     = 0;
            for (int k = 0; k < DW; k++) begin
                cyc();
                #1;
                if (dout_valid === 1'b1) run++;
                n_cmp++;
                if ({dout_id, dout, dout_last} !== {id_exp, words[id_exp][k], (k == DW - 1)}) begin
                    n_fail++;
                    $display("FAIL rr_w%0d_b%0d got id/dout/last=%0d/%b/%b want %0d/%b/%b",
                             w, k, dout_id, dout, dout_last, id_exp, words[id_exp][k], (k == DW - 1));
                end
                if (k == DW - 1) begin
                    n_cmp++;
                    if (req_ready !== rdy_exp) begin
                        n_fail++; $display("FAIL rr_w%0d_ready got=%b want=%b", w, req_ready, rdy_exp);
                    end
                    if (w == 4) req_valid = '0;
                end
            end
            n_cmp++;
            if (run != DW) begin n_fail++; $display("FAIL rr_w%0d_valid_run got=%0d want=%0d", w, run, DW); end
        end
        cyc();
        #1;
        n_cmp++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rr_end_idle got valid=%b want=0", dout_valid); end
    endtask

    task automatic test_ptr_wrap();
        words[1] = 16'h1234;
        words[3] = 16'h8001;
        load_words();
        do_reset();
        req_valid = 4'b1000;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready3 got=%b want=1000", req_ready); end
        cyc();
        req_valid = '0;
        for (int k = 0; k < DW; k++) cyc();
        req_valid = 4'b1010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_ready1 got=%b want=0010", req_ready); end
        cyc();
        #1;
        n_cmp++;
        if ({dout_valid, dout_id} !== {1'b1, 2'd1}) begin
            n_fail++; $display("FAIL wrap_id got valid/id=%b/%0d want 1/1", dout_valid, dout_id);
        end
        for (int k = 1; k < DW; k++) cyc();
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_next_ready got=%b want=1000", req_ready); end
        req_valid = '0;
        cyc();
    endtask

    task automatic test_stall();
        int run;
        int last_at;
        int t;
        words[2] = 16'hFFFF;
        load_words();
        do_reset();
        req_valid = 4'b0100;
        cyc();
        req_valid = '0;
        run     = 0;
        last_at = -1;
        t       = 0;
        for (int c = 0; c < DW + 3; c++) begin
            stall = (c >= 6 && c < 9);
            #1;
            if (dout_valid === 1'b1) run++;
            if (dout_last === 1'b1 && dout_valid === 1'b1) last_at = t;
            n_cmp++;
            if (dout_valid !== !stall) begin
                n_fail++; $display("FAIL stall_c%0d got valid=%b want=%b", c, dout_valid, !stall);
            end
            n_cmp++;
            if ({dout, dout_id, req_ready} !== {1'b1, 2'd2, 4'b0000}) begin
                n_fail++; $display("FAIL stall_data_c%0d got dout/id/ready=%b/%0d/%b want 1/2/0000", c, dout, dout_id, req_ready);
            end
            t++;
            cyc();
        end
        stall = 1'b0;
        n_cmp++;
        if (run != DW) begin n_fail++; $display("FAIL stall_run got=%0d want=%0d", run, DW); end
        n_cmp++;
        if (last_at != DW + 2) begin n_fail++; $display("FAIL stall_last_cycle got=%0d want=%0d", last_at, DW + 2); end
        #1;
        n_cmp++;
        if ({dout_valid, dout} !== 2'b00) begin n_fail++; $display("FAIL stall_idle got valid/dout=%b want=00", {dout_valid, dout}); end
    endtask

    task automatic test_reset_mid_word();
        words[0] = 16'hFFFF;
        words[1] = 16'hFFFF;
        words[3] = 16'hFFFF;
        load_words();
        do_reset();
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        for (int k = 0; k < 7; k++) cyc();
        reset     = 1'b1;
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if ({dout_valid, dout, dout_id} !== {1'b1, 1'b1, 2'd1}) begin
            n_fail++; $display("FAIL rst_mid_bit7 got valid/dout/id=%b/%b/%0d want 1/1/1", dout_valid, dout, dout_id);
        end
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ready got=%b want=0000", req_ready); end
        cyc();
        reset     = 1'b0;
        req_valid = '0;
        #1;
        n_cmp++;
        if ({dout, dout_valid, dout_last, dout_id, req_ready} !== 9'b0) begin
            n_fail++; $display("FAIL rst_mid_outs got dout/valid/last/id/ready=%b/%b/%b/%0d/%b want all zero",
                               dout, dout_valid, dout_last, dout_id, req_ready);
        end
        cyc();
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_regrant got=%b want=0001", req_ready); end
        cyc();
        req_valid = '0;
        #1;
        n_cmp++;
        if ({dout_valid, dout_id} !== {1'b1, 2'd0}) begin
            n_fail++; $display("FAIL rst_mid_newid got valid/id=%b/%0d want 1/0", dout_valid, dout_id);
        end
    endtask

    task automatic test_stall_idle();
        words[0] = 16'h0001;
        load_words();
        do_reset();
        stall     = 1'b1;
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if ({req_ready, dout_valid} !== 5'b0) begin
                n_fail++; $display("FAIL idle_stall_c%0d got ready/valid=%b/%b want 0000/0", c, req_ready, dout_valid);
            end
            cyc();
        end
        stall = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL idle_unstall_ready got=%b want=0001", req_ready); end
        cyc();
        req_valid = '0;
        #1;
        n_cmp++;
        if ({dout_valid, dout, dout_id} !== {1'b1, 1'b1, 2'd0}) begin
            n_fail++; $display("FAIL idle_unstall_bit0 got valid/dout/id=%b/%b/%0d want 1/1/0", dout_valid, dout, dout_id);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) words[i] = '0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_ptr_wrap();
        test_stall();
        test_reset_mid_word();
        test_stall_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
